gpu_warp_sequencer: RTL and testbench

GPU_WARP_SEQUENCER -- requirements
Module: gpu_warp_sequencer

---
 rtl/gpu_warp_sequencer.sv | 167 ++++++++++++++++
 tb/tb_gpu_warp_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_warp_sequencer.sv
// Round-robin warp sequencer: fetches one instruction per active thread and dispatches it by unit class.
// Define GPU_ILLEGAL_TRAP_EN to trap illegal opcodes per thread; otherwise they retire as NOPs.
module gpu_warp_sequencer #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned IMEM_DEPTH  = 16,
  parameter int unsigned OPND_W      = 33,
  localparam int unsigned AW = $clog2(IMEM_DEPTH),
  localparam int unsigned IW = 6 + 2 * OPND_W,
  localparam int unsigned TW = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_we,
  input  logic [AW-1:0]          imem_addr,
  input  logic [IW-1:0]          imem_wdata,
  input  logic                   start,
  input  logic [AW-1:0]          start_pc,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic                   disp_math,
  output logic                   disp_cond,
  output logic                   disp_fpu,
  output logic                   disp_io,
  output logic [TW-1:0]          disp_tid,
  output logic [5:0]             disp_opcode,
  output logic [OPND_W-1:0]      disp_op1,
  output logic [OPND_W-1:0]      disp_op2,
  output logic [NUM_THREADS-1:0] thread_active,
  output logic [NUM_THREADS-1:0] thread_err,
  output logic                   busy,
  output logic                   done
);

`ifdef GPU_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          mem [IMEM_DEPTH];
  logic [IW-1:0]          ir_q;
  logic [AW-1:0]          pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q, err_q;
  logic [TW-1:0]          tid_q, rr_q;

  logic          sel_found;
  logic [TW-1:0] sel_tid, cand;
  int unsigned   idx;
  logic          fire, do_stop, do_nop, do_trap;

  logic [5:0] opcode;
  logic       is_math, is_fpu, is_cond, is_io, is_stop, is_disp;

  assign opcode  = ir_q[IW-1 -: 6];
  assign is_math = (opcode <= 6'd13);
  assign is_fpu  = (opcode >= 6'd14) && (opcode <= 6'd22);
  assign is_cond = (opcode >= 6'd23) && (opcode <= 6'd27);
  assign is_io   = (opcode >= 6'd28) && (opcode <= 6'd31);
  assign is_stop = (opcode == 6'd63);
  assign is_disp = is_math | is_fpu | is_cond | is_io;

  // Search starts one past the last selected thread.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
      cand = TW'(idx);
      if (!sel_found && active_q[cand]) begin
        sel_found = 1'b1;
        sel_tid   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    disp_valid = 1'b0;
    done       = 1'b0;
    fire       = 1'b0;
    do_stop    = 1'b0;
    do_nop     = 1'b0;
    do_trap    = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        if (sel_found) begin
          state_d = StIssue;
        end else begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (is_disp) begin
          disp_valid = 1'b1;
          if (disp_ready) begin
            fire    = 1'b1;
            state_d = StFetch;
          end
        end else if (is_stop) begin
          do_stop = 1'b1;
          state_d = StFetch;
        end else begin
          if (TrapEn) do_trap = 1'b1;
          else        do_nop  = 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      active_q <= '0;
      err_q    <= '0;
      tid_q    <= '0;
      rr_q     <= '0;
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        active_q <= '1;
        err_q    <= '0;
        rr_q     <= TW'(NUM_THREADS - 1);
        for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= start_pc;
      end
      if (state_q == StFetch && sel_found) begin
        tid_q <= sel_tid;
        rr_q  <= sel_tid;
      end
      if (fire || do_nop) pc_q[tid_q] <= pc_q[tid_q] + 1'b1;
      if (do_stop || do_trap) active_q[tid_q] <= 1'b0;
      if (do_trap) err_q[tid_q] <= 1'b1;
    end
  end

  // Memory and instruction register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && imem_we && state_q == StIdle) mem[imem_addr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == StFetch && sel_found) ir_q <= mem[pc_q[sel_tid]];
  end

  assign disp_math     = disp_valid & is_math;
  assign disp_fpu      = disp_valid & is_fpu;
  assign disp_cond     = disp_valid & is_cond;
  assign disp_io       = disp_valid & is_io;
  assign disp_tid      = tid_q;
  assign disp_opcode   = opcode;
  assign disp_op1      = ir_q[2*OPND_W-1 -: OPND_W];
  assign disp_op2      = ir_q[OPND_W-1:0];
  assign thread_active = active_q;
  assign thread_err    = err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_gpu_warp_sequencer.sv
// Directed bench for gpu_warp_sequencer: dispatch order, stalls, PC wrap, reset, illegal opcodes.
module tb_gpu_warp_sequencer;
  localparam int unsigned NT = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OW = 33;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 72;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst, imem_we, start, disp_ready;
  logic [AW-1:0] imem_addr, start_pc;
  logic [IW-1:0] imem_wdata;
  logic          disp_valid, disp_math, disp_cond, disp_fpu, disp_io, busy, done;
  logic [TW-1:0] disp_tid;
  logic [5:0]    disp_opcode;
  logic [OW-1:0] disp_op1, disp_op2;
  logic [NT-1:0] thread_active, thread_err;

  always #5 clk = ~clk;

  gpu_warp_sequencer #(.NUM_THREADS(NT), .IMEM_DEPTH(DEPTH), .OPND_W(OW)) dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .start(start), .start_pc(start_pc), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_math(disp_math), .disp_cond(disp_cond), .disp_fpu(disp_fpu), .disp_io(disp_io),
    .disp_tid(disp_tid), .disp_opcode(disp_opcode), .disp_op1(disp_op1), .disp_op2(disp_op2),
    .thread_active(thread_active), .thread_err(thread_err), .busy(busy), .done(done)
  );

  int n_total = 0;
  int n_bad = 0;
  int ndisp, done_cyc, first_cyc;
  logic [TW-1:0] tid_log[$];
  logic [3:0]    cls_log[$];
  logic [5:0]    op_log[$];

  // Class nibble order: {math, cond, fpu, io}
  localparam logic [3:0] ClsMath = 4'b1000;
  localparam logic [3:0] ClsFpu  = 4'b0010;
  localparam logic [3:0] ClsIo   = 4'b0001;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] instr(input logic [5:0] op, input logic [OW-1:0] a,
                                          input logic [OW-1:0] b);
    return {op, a, b};
  endfunction

  // All tasks begin and end just after a falling edge.
  task automatic wr(input int addr, input logic [IW-1:0] d);
    imem_we = 1'b1; imem_addr = AW'(addr); imem_wdata = d;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic kick(input int pc);
    start = 1'b1; start_pc = AW'(pc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int budget);
    logic [3:0] cls;
    ndisp = 0; done_cyc = 0; first_cyc = 0;
    tid_log.delete(); cls_log.delete(); op_log.delete();
    for (int c = 1; c <= budget; c++) begin
      cls = {disp_math, disp_cond, disp_fpu, disp_io};
      if (disp_valid) begin
        check("onehot", 128'($onehot(cls)), 1);
        if (disp_ready) begin
          ndisp++;
          tid_log.push_back(disp_tid);
          cls_log.push_back(cls);
          op_log.push_back(disp_opcode);
          if (first_cyc == 0) first_cyc = c;
        end
      end else begin
        check("cls_zero", cls, 0);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_run(input string tag, input int exp_n, input logic [3:0] exp_cls,
                            input int exp_done);
    check({tag, "_ndisp"}, ndisp, exp_n);
    for (int i = 0; i < tid_log.size(); i++) begin
      check({tag, "_tid"}, tid_log[i], i);
      check({tag, "_cls"}, cls_log[i], exp_cls);
    end
    check({tag, "_done_cyc"}, done_cyc, exp_done);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_active_after"}, thread_active, 0);
  endtask

  task automatic load_basic();
    wr(0, instr(6'd5, 33'h1_0000_0001, 33'h0_0000_0002));
    wr(1, instr(6'd63, '0, '0));
  endtask

  initial begin
    rst = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    start = 1'b0; start_pc = '0; disp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_active", thread_active, 0);
    check("rst_err", thread_err, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) wr(a, instr(6'd63, '0, '0));

    // Basic round-robin dispatch then STOP on every thread
    load_basic();
    kick(0);
    check("b_busy", busy, 1);
    check("b_active", thread_active, 4'b1111);
    run(60);
    check("b_first_cyc", first_cyc, 2);
    if (op_log.size() > 0) check("b_opcode", op_log[0], 5);
    expect_run("basic", 4, ClsMath, 17);

    // Downstream stall on an fpu op
    wr(0, instr(6'd14, 33'h1_2345_6789, 33'h0_0BAD_F00D));
    disp_ready = 1'b0;
    kick(0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("st_valid", disp_valid, 1);
      check("st_fpu", disp_fpu, 1);
      check("st_tid", disp_tid, 0);
      check("st_opcode", disp_opcode, 14);
      check("st_op1", disp_op1, 33'h1_2345_6789);
      check("st_op2", disp_op2, 33'h0_0BAD_F00D);
      if (k < 5) @(negedge clk);
    end
    disp_ready = 1'b1;
    run(60);
    expect_run("stall", 4, ClsFpu, 16);

    // PC wrap from 15 to 0
    wr(15, instr(6'd28, '0, 33'h5));
    wr(0, instr(6'd63, '0, '0));
    kick(15);
    run(60);
    expect_run("wrap", 4, ClsIo, 17);

    // Reset in the middle of a pending dispatch, then rerun
    load_basic();
    disp_ready = 1'b0;
    kick(0);
    @(negedge clk);
    check("mr_pre_valid", disp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_busy", busy, 0);
    check("mr_valid", disp_valid, 0);
    check("mr_active", thread_active, 0);
    check("mr_done", done, 0);
    check("mr_cls", {disp_math, disp_cond, disp_fpu, disp_io}, 0);
    rst = 1'b0;
    disp_ready = 1'b1;
    kick(0);
    run(60);
    expect_run("rerun", 4, ClsMath, 17);

    // Illegal opcode at addr0
    wr(0, instr(6'd40, '0, '0));
    wr(1, instr(6'd5, '0, '0));
    wr(2, instr(6'd63, '0, '0));
    kick(0);
    run(80);
`ifdef GPU_ILLEGAL_TRAP_EN
    check("ill_err", thread_err, 4'b1111);
    expect_run("ill", 0, ClsMath, 9);
`else
    check("ill_err", thread_err, 4'b0000);
    expect_run("ill", 4, ClsMath, 25);
`endif

    // Write and start while busy are both ignored
    load_basic();
    kick(0);
    imem_we = 1'b1; imem_addr = '0; imem_wdata = instr(6'd20, '0, '0);
    start = 1'b1;
    @(negedge clk);
    imem_we = 1'b0; start = 1'b0;
    run(60);
    expect_run("busy_wr", 4, ClsMath, 16);
    kick(0);
    run(60);
    expect_run("busy_wr_rerun", 4, ClsMath, 17);

    // Reset wins over start and imem_we
    rst = 1'b1; start = 1'b1;
    imem_we = 1'b1; imem_addr = '0; imem_wdata = instr(6'd20, '0, '0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; imem_we = 1'b0;
    check("prio_busy", busy, 0);
    kick(0);
    run(60);
    expect_run("prio", 4, ClsMath, 17);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
